ps2_keymap: RTL and testbench
=============================

# ps2_keymap

Parametrised PS/2 scan-code decoder that turns a stream of received bytes into per-key held/pressed/released flags for the game controller. Sits between the PS/2 byte receiver and the player-control logic. Adds extended (E0) key support, make/break edge pulses, typematic-repeat suppression, a prefix timeout and a keyboard-reset flush on top of the fixed five-key decoder it supersedes. All logic runs in the single `clk` domain.

## Interface
- NUM_KEYS, 5, number of decoded keys (1..32)
- KEY_CODES, {9'h029, 9'h01B, 9'h023, 9'h01D, 9'h01C}, NUM_KEYS×9 packed table; entry i = KEY_CODES[9*i +: 9], bit 8 = extended (E0) flag, bits 7:0 = set-2 make code; default index 0..4 = A, W, D, S, Space
- TIMEOUT_CYCLES, 2_000_000, clk cycles a prefix may wait for its next byte (≥2); counter width = $clog2(TIMEOUT_CYCLES+1)
- clk  in  1  system clock; one clock, reset is synchronous and active-high
- rst  in  1  synchronous reset, active-high
- done  in  1  one-cycle strobe, clk-domain: data valid this cycle
- data  in  8  received byte
- key_down  out  NUM_KEYS  level, bit i = key i held
- key_press  out  NUM_KEYS  one-cycle pulse on key i down transition
- key_release  out  NUM_KEYS  one-cycle pulse on key i up transition
- any_down  out  1  OR of key_down
- busy  out  1  FSM not in IDLE (prefix pending)

## Operation
- FSM states: IDLE, EXT (E0 seen), BRK (F0 seen), EXT_BRK (E0 and F0 seen).
- On done: E0 → IDLE→EXT, BRK→EXT_BRK, EXT/EXT_BRK stay. F0 → IDLE→BRK, EXT→EXT_BRK, BRK/EXT_BRK stay.
- Any other byte b (non-prefix, non-status) completes a code: ext = state∈{EXT, EXT_BRK}, brk = state∈{BRK, EXT_BRK}; FSM → IDLE.
- Match: key i matches when KEY_CODES[9*i +: 9] == {ext, b}. All matching entries update (duplicates allowed). Unmatched code: no output change, FSM → IDLE.
- Make (brk=0): key_down[i] ← 1; key_press[i] pulses only if key_down[i] was 0 (typematic repeats produce no pulse).
- Break (brk=1): key_down[i] ← 0; key_release[i] pulses only if key_down[i] was 1.
- Status bytes 00, AA, FC, FF (overrun/BAT/error): all key_down ← 0, key_release pulses for every bit previously 1, FSM → IDLE, regardless of state.
- Status bytes EE, FA, FE (echo/ack/resend): ignored; state unchanged.
- Timeout: counter clears on every done; increments while busy and no done; when it reaches TIMEOUT_CYCLES, FSM → IDLE, counter clears, no key change.
- any_down, busy combinational from registered key_down/state.

## Timing
- Reset: key_down, key_press, key_release = 0; state IDLE; counter 0; any_down=0, busy=0. done in a rst cycle is ignored.
- Latency: done at edge N → key_down/key_press/key_release/state visible after edge N+1 (one register stage).
- key_press/key_release high exactly one cycle, then 0 unless another done follows immediately.
- done on consecutive cycles supported; each byte processed in order, no stall, no backpressure.
- done in the cycle the timeout would fire: byte wins, processed against current state, counter clears.
- rst mid-sequence (e.g. after E0 F0): state IDLE, held keys cleared, no release pulses.

## Test plan
- Make/break: done with 1C, then F0, then 1C → key_down[0] 0→1 with key_press=5'b00001 one cycle; after 1C break key_down=0, key_release=5'b00001 one cycle, busy high only between F0 and 1C.
- Typematic: 1D ×3 → key_down[1]=1, exactly one key_press[1] pulse; F0 1D → one key_release[1] pulse; second F0 1D → no pulse.
- Extended: KEY_CODES entry 0 = 9'h175 (up arrow); E0 75 → key_down[0]=1; plain 75 → no change; E0 F0 75 → key_down[0]=0 with release pulse.
- Multi-key and flush: press 1C, 23, 29 → key_down=5'b10101, any_down=1; AA → key_down=0, key_release=5'b10101 same cycle.
- Timeout: TIMEOUT_CYCLES=16; F0 then idle 16 cycles → busy drops at cycle 16; then 1C → treated as make, key_down[0]=1.
- Reset/ignore: press 1B, send FA (ignored, key_down[3] stays 1), then E0 F0, assert rst → all outputs 0, busy 0, no pulses.

Source files
------------

// File: rtl/ps2_keymap.sv
// ps2_keymap
// ----------
// Turns the byte stream from a PS/2 receiver (scan-code set 2) into per-key
// held / pressed / released flags for a configurable table of keys.
//
// Handshake: `done` is a one-cycle valid strobe that qualifies `data`.
// There is no ready signal. Every strobed byte is consumed in the cycle
// it is presented, and back-to-back strobes are accepted.
//
// Parameters
//   NUM_KEYS        number of decoded keys (1..32)
//   KEY_CODES       packed table, entry i = KEY_CODES[9*i +: 9];
//                   bit 8 = E0-extended flag, bits 7:0 = make code
//   TIMEOUT_CYCLES  cycles a pending prefix may wait for its next byte (>=2)
//
// Ports
//   clk          system clock
//   rst          synchronous reset, active-high
//   done         byte-valid strobe
//   data         received byte
//   key_down     level, bit i = key i held
//   key_press    one-cycle pulse when key i goes down
//   key_release  one-cycle pulse when key i goes up
//   any_down     OR of key_down
//   busy         a prefix (E0 and/or F0) is pending
module ps2_keymap #(
    parameter int                      NUM_KEYS       = 5,
    parameter logic [9*NUM_KEYS-1:0]   KEY_CODES      = {9'h029, 9'h01B, 9'h023, 9'h01D, 9'h01C},
    parameter int                      TIMEOUT_CYCLES = 2_000_000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                done,
    input  logic [7:0]          data,
    output logic [NUM_KEYS-1:0] key_down,
    output logic [NUM_KEYS-1:0] key_press,
    output logic [NUM_KEYS-1:0] key_release,
    output logic                any_down,
    output logic                busy
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    // The prefix is dropped on the edge where the counter would reach
    // TIMEOUT_CYCLES, so compare against one less than that.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    // Bit 0 = E0 seen, bit 1 = F0 seen; the two flags are read directly
    // when a code completes.
    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        EXT     = 2'b01,
        BRK     = 2'b10,
        EXT_BRK = 2'b11
    } state_t;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [NUM_KEYS-1:0]  key_down_q, key_down_d;
    logic [NUM_KEYS-1:0]  key_press_q, key_press_d;
    logic [NUM_KEYS-1:0]  key_release_q, key_release_d;

    logic is_flush;
    logic is_ignore;
    logic code_ext;
    logic code_brk;

    // Overrun / BAT-ok / BAT-fail / error: the keyboard state is unknown.
    assign is_flush  = (data == 8'h00) || (data == 8'hAA) ||
                       (data == 8'hFC) || (data == 8'hFF);
    // Echo / ack / resend replies carry no key information.
    assign is_ignore = (data == 8'hEE) || (data == 8'hFA) || (data == 8'hFE);

    assign code_ext = state_q[0];
    assign code_brk = state_q[1];

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        key_down_d    = key_down_q;
        key_press_d   = '0;
        key_release_d = '0;

        if (done) begin
            cnt_d = '0;
            if (data == 8'hE0) begin
                state_d = state_t'({state_q[1], 1'b1});
            end else if (data == 8'hF0) begin
                state_d = state_t'({1'b1, state_q[0]});
            end else if (is_flush) begin
                key_release_d = key_down_q;
                key_down_d    = '0;
                state_d       = IDLE;
            end else if (is_ignore) begin
                state_d = state_q;
            end else begin
                state_d = IDLE;
                // Every matching entry updates, so duplicated codes drive
                // several bits at once.
                for (int i = 0; i < NUM_KEYS; i++) begin
                    if (KEY_CODES[9*i +: 9] == {code_ext, data}) begin
                        if (code_brk) begin
                            key_down_d[i]    = 1'b0;
                            key_release_d[i] = key_down_q[i];
                        end else begin
                            key_down_d[i]  = 1'b1;
                            key_press_d[i] = ~key_down_q[i];
                        end
                    end
                end
            end
        end else if (state_q != IDLE) begin
            if (cnt_q == CNT_LAST) begin
                state_d = IDLE;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            key_down_q    <= '0;
            key_press_q   <= '0;
            key_release_q <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            key_down_q    <= key_down_d;
            key_press_q   <= key_press_d;
            key_release_q <= key_release_d;
        end
    end

    assign key_down    = key_down_q;
    assign key_press   = key_press_q;
    assign key_release = key_release_q;
    assign any_down    = |key_down_q;
    assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_ps2_keymap.sv
module tb_ps2_keymap;

    localparam int NK = 7;
    localparam int TO = 16;
    // idx0..4 = default keys, idx5 = E0 75 (up arrow), idx6 = duplicate of 1C
    localparam logic [9*NK-1:0] CODES =
        {9'h01C, 9'h175, 9'h029, 9'h01B, 9'h023, 9'h01D, 9'h01C};

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          done = 1'b0;
    logic [7:0]    data = 8'h00;
    logic [NK-1:0] key_down, key_press, key_release;
    logic          any_down, busy;

    ps2_keymap #(.NUM_KEYS(NK), .KEY_CODES(CODES), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst), .done(done), .data(data),
        .key_down(key_down), .key_press(key_press), .key_release(key_release),
        .any_down(any_down), .busy(busy)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    // ---------------- bookkeeping ----------------
    int  n_total = 0;
    int  n_pass  = 0;
    bit  chk_en  = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // ---------------- behavioural model ----------------
    logic [8:0]    tbl [NK] = '{9'h01C, 9'h01D, 9'h023, 9'h01B, 9'h029, 9'h175, 9'h01C};
    logic [NK-1:0] m_down = '0, m_press = '0, m_rel = '0;
    bit            m_ext = 0, m_brk = 0;
    int            m_wait = 0;

    always @(posedge clk) begin
        m_press = '0;
        m_rel   = '0;
        if (rst) begin
            m_down = '0; m_ext = 0; m_brk = 0; m_wait = 0;
        end else if (done) begin
            m_wait = 0;
            case (data)
                8'hE0: m_ext = 1;
                8'hF0: m_brk = 1;
                8'h00, 8'hAA, 8'hFC, 8'hFF: begin
                    m_rel = m_down; m_down = '0; m_ext = 0; m_brk = 0;
                end
                8'hEE, 8'hFA, 8'hFE: ;
                default: begin
                    for (int k = 0; k < NK; k++) begin
                        if (tbl[k] == {m_ext, data}) begin
                            if (m_brk) begin
                                if (m_down[k]) m_rel[k] = 1'b1;
                                m_down[k] = 1'b0;
                            end else begin
                                if (!m_down[k]) m_press[k] = 1'b1;
                                m_down[k] = 1'b1;
                            end
                        end
                    end
                    m_ext = 0; m_brk = 0;
                end
            endcase
        end else if (m_ext || m_brk) begin
            m_wait = m_wait + 1;
            if (m_wait == TO) begin
                m_ext = 0; m_brk = 0; m_wait = 0;
            end
        end
    end

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        if (chk_en) begin
            check("key_down",    32'(key_down),    32'(m_down));
            check("key_press",   32'(key_press),   32'(m_press));
            check("key_release", 32'(key_release), 32'(m_rel));
            check("any_down",    32'(any_down),    32'(|m_down));
            check("busy",        32'(busy),        32'(m_ext | m_brk));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send(input logic [7:0] b);
        done = 1'b1;
        data = b;
        @(posedge clk); #1;
        done = 1'b0;
    endtask

    task automatic idle(input int n);
        done = 1'b0;
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic pulse_rst(input bit with_done);
        rst  = 1'b1;
        done = with_done;
        data = 8'h1C;
        @(posedge clk); #1;
        rst  = 1'b0;
        done = 1'b0;
    endtask

    function automatic logic [7:0] rand_byte();
        int r;
        r = $urandom_range(0, 15);
        if (r <= 6)       rand_byte = tbl[$urandom_range(0, NK-1)][7:0];
        else if (r <= 8)  rand_byte = 8'hE0;
        else if (r <= 10) rand_byte = 8'hF0;
        else if (r == 11) begin
            case ($urandom_range(0, 3))
                0: rand_byte = 8'h00; 1: rand_byte = 8'hAA;
                2: rand_byte = 8'hFC; default: rand_byte = 8'hFF;
            endcase
        end else if (r == 12) begin
            case ($urandom_range(0, 2))
                0: rand_byte = 8'hEE; 1: rand_byte = 8'hFA; default: rand_byte = 8'hFE;
            endcase
        end else rand_byte = 8'($urandom_range(0, 255));
    endfunction

    // ---------------- stimulus ----------------
    initial begin
        @(posedge clk); #1;
        chk_en = 1'b1;
        idle(1);
        rst = 1'b0;
        check("rst_down", 32'(key_down), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        idle(2);

        // make / break of 1C (drives idx0 and its duplicate idx6)
        send(8'h1C);
        check("mk_down",  32'(key_down),  32'(7'b1000001));
        check("mk_press", 32'(key_press), 32'(7'b1000001));
        send(8'hF0);
        check("f0_busy",  32'(busy), 32'd1);
        check("f0_press", 32'(key_press), 32'd0);
        send(8'h1C);
        check("brk_down", 32'(key_down),    32'd0);
        check("brk_rel",  32'(key_release), 32'(7'b1000001));
        check("brk_busy", 32'(busy), 32'd0);
        idle(2);

        // typematic repeat
        send(8'h1D);
        check("typ_press1", 32'(key_press), 32'(7'b0000010));
        send(8'h1D);
        check("typ_press2", 32'(key_press), 32'd0);
        send(8'h1D);
        check("typ_down", 32'(key_down), 32'(7'b0000010));
        send(8'hF0); send(8'h1D);
        check("typ_rel", 32'(key_release), 32'(7'b0000010));
        send(8'hF0); send(8'h1D);
        check("typ_rel2", 32'(key_release), 32'd0);
        idle(1);

        // extended key
        send(8'hE0); send(8'h75);
        check("ext_down", 32'(key_down), 32'(7'b0100000));
        send(8'h75);
        check("plain75", 32'(key_down), 32'(7'b0100000));
        send(8'hE0); send(8'hF0); send(8'h75);
        check("ext_rel", 32'(key_release), 32'(7'b0100000));
        check("ext_up",  32'(key_down), 32'd0);

        // multi-key and flush
        send(8'h1C); send(8'h23); send(8'h29);
        check("multi_down", 32'(key_down), 32'(7'b1010101));
        check("multi_any",  32'(any_down), 32'd1);
        send(8'hAA);
        check("flush_down", 32'(key_down),    32'd0);
        check("flush_rel",  32'(key_release), 32'(7'b1010101));

        // prefix timeout
        send(8'hF0);
        idle(TO - 1);
        check("to_busy_hi", 32'(busy), 32'd1);
        idle(1);
        check("to_busy_lo", 32'(busy), 32'd0);
        send(8'h1C);
        check("to_make", 32'(key_down), 32'(7'b1000001));
        // a byte arriving on the timeout cycle is still treated as a break
        send(8'hF0);
        idle(TO - 1);
        send(8'h1C);
        check("to_edge_rel", 32'(key_release), 32'(7'b1000001));

        // ignored status byte, then reset mid-prefix with a strobe in rst
        send(8'h1B);
        send(8'hFA);
        check("ign_down", 32'(key_down), 32'(7'b0001000));
        send(8'hE0); send(8'hF0);
        pulse_rst(1'b1);
        check("rst2_down", 32'(key_down), 32'd0);
        check("rst2_rel",  32'(key_release), 32'd0);
        check("rst2_busy", 32'(busy), 32'd0);
        idle(2);

        // randomized traffic
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(0, 299) == 0) pulse_rst($urandom_range(0, 1) == 1);
            send(rand_byte());
            case ($urandom_range(0, 9))
                0, 1, 2, 3: ;
                4, 5, 6: idle($urandom_range(1, 3));
                7, 8: idle($urandom_range(TO - 2, TO + 1));
                default: idle($urandom_range(4, 12));
            endcase
        end

        idle(3);
        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
